exc_commit_ctrl: RTL and testbench
==================================

// Module: exc_commit_ctrl
// PURPOSE
//  WB-stage exception/interrupt commit controller, directly upstream of CP0.
//  Registers MEM-stage exception flags into WB and prioritises them against pending interrupts.
//  Drives CP0's wb_exception_* / exception_inst_interrupt / inst_eret inputs.
//  Owns the pipeline flush and the fetch redirect handshake for exceptions and ERET.
// PARAMETERS
//  EXC_VECTOR  32'hBFC0_0380  exception entry PC (BEV=1)
//  PC_W        32             PC/address width
// PORTS
//  clk                      in   1   clock; all state on posedge
//  reset                    in   1   asynchronous, active-high
//  ready, complete          in   1   WB advance qualifier; same signals CP0 samples
//  mem_valid                in   1   MEM slot holds a live instruction
//  mem_pc                   in   32  PC of MEM instruction
//  mem_bd                   in   1   MEM instruction sits in a delay slot
//  mem_exc_{fadel,ri,ov,sys,bp,adel,ades} in 1 each  raw exception flags
//  mem_data_addr            in   32  load/store effective address
//  mem_eret                 in   1   MEM instruction is ERET
//  cp0_status_ie, cp0_status_exl, cp0_status_im0, cp0_status_im1  in 1 each  from CP0
//  cp0_cause_ip0, cp0_cause_ip1  in 1 each  software interrupt pending, from CP0
//  cp0_epc_val              in   32  bypassed EPC (ERET target)
//  cp0_status_val           in   32  bypassed Status (IM[15:10] for hw ints)
//  hw_int                   in   6   async hardware interrupt lines (used only with macro)
//  redirect_ack             in   1   fetch has accepted redirect_pc
//  exception_inst_interrupt out  1   to CP0
//  wb_exception_inst_exchappen, _bd, _badvaddr_wren   out 1 each  to CP0
//  wb_exception_inst_epc, _badvaddr  out 32  to CP0
//  wb_exception_inst_exccode         out 5   to CP0
//  inst_eret                out  1   to CP0
//  flush                    out  1   kill IF..MEM this cycle
//  redirect_valid           out  1   redirect request to fetch
//  redirect_pc              out  32  redirect target
// BEHAVIOUR
//  WB regs load MEM fields when ready&&complete; wb_valid<=mem_valid && state==IDLE && !flush.
//  Priority: Int(0) > FADEL(4) > RI(10) > Ov(12) > Sys(8) > Bp(9) > ADEL(4) > ADES(5).
//  int_pend = ie & ~exl & ((ip0&im0)|(ip1&im1)|hw_term); evaluated combinationally.
//  exception_inst_interrupt = wb_valid & int_pend & state==IDLE.
//  exchappen = wb_valid & any flag & ~interrupt; exccode = highest-priority code; 0 for interrupt.
//  epc = bd ? wb_pc-4 : wb_pc; _bd = wb_bd. badvaddr = wb_pc (FADEL) or wb_data_addr (ADEL/ADES).
//  badvaddr_wren only for those three codes.
//  inst_eret = wb_valid & wb_eret & ~interrupt & ~exchappen.
//  FSM IDLE/REDIR. IDLE: trigger = ready&&complete&&(interrupt|exchappen|inst_eret).
//   On trigger: flush=1 (same cycle, single pulse), latch target, ->REDIR.
//   Target: EXC_VECTOR, or cp0_epc_val for ERET.
//  REDIR: redirect_valid=1, redirect_pc stable; WB capture blocked (wb_valid forced 0).
//   On redirect_ack ->IDLE.
//  redirect_ack in IDLE ignored. Trigger without ready&&complete: outputs held, no flush, no state change.
//  Reset (any time, incl. REDIR): state=IDLE, wb_valid=0, all outputs 0, redirect_pc=EXC_VECTOR.
//  Flag combinations without mem_valid are ignored (wb_valid=0 gates every output).
// CONFIGURATION
//  EXC_HWINT_EN defined:
//   hw_int passes two-flop synchronisers (reset 0).
//   hw_term = |(hw_int_sync & cp0_status_val[15:10]).
//  Undefined: hw_int unused, no flops, hw_term=0.
// STRUCTURE
//  Package exc_pkg: EXC_INT/ADEL/ADES/SYS/BP/RI/OV codes; exc_flags_t struct; EXC_VECTOR default.
//  Package exc_pkg also holds the state enum.
//  Sub-module exc_prio_enc: combinational flags -> {hit, exccode, badvaddr_sel}.
// TESTING
//  1. ADD overflow, pc=0x80001000, bd=0, ready&&complete -> exccode=12, epc=0x80001000.
//     Same cycle: flush pulse, redirect_pc=0xBFC00380 held until ack.
//  2. Delay-slot FADEL, pc=0x80000004, bd=1 -> exccode=4, epc=0x80000000.
//     badvaddr=0x80000004, badvaddr_wren=1.
//  3. ie=1, exl=0, im0=1, ip0=1 plus RI in WB -> interrupt=1, exchappen=0, redirect to vector.
//  4. ERET with cp0_epc_val=0x80002000 -> inst_eret=1, flush, redirect_pc=0x80002000.
//  5. Trigger with complete=0 for 3 cycles -> no flush/state change; fires on 4th cycle.
//  6. Reset asserted in REDIR before ack -> immediate redirect_valid=0, state IDLE.
//     With EXC_HWINT_EN: hw_int[0]=1, IM2=1 -> interrupt visible 2 cycles later.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared exception codes, flag bundle, badvaddr source select and commit FSM states
// for the WB-stage exception commit controller.
package exc_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

  // Field order matters: the top packs raw MEM flags positionally in this order.
  typedef struct packed {
    logic fadel;
    logic ri;
    logic ov;
    logic sys;
    logic bp;
    logic adel;
    logic ades;
  } exc_flags_t;

  typedef enum logic [1:0] {
    BV_NONE = 2'd0,
    BV_PC   = 2'd1,
    BV_DATA = 2'd2
  } bv_sel_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_REDIR = 1'b1
  } commit_state_e;

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority exception encoder: picks the winning synchronous exception code
// and tells the top where BadVAddr comes from.
module exc_prio_enc
  import exc_pkg::*;
(
  input  exc_flags_t   i_flags,
  output logic         o_hit,
  output logic [4:0]   o_exccode,
  output bv_sel_e      o_bv_sel
);

  always_comb begin
    o_hit     = 1'b1;
    o_exccode = EXC_INT;
    o_bv_sel  = BV_NONE;
    if (i_flags.fadel) begin
      o_exccode = EXC_ADEL;
      o_bv_sel  = BV_PC;
    end else if (i_flags.ri) begin
      o_exccode = EXC_RI;
    end else if (i_flags.ov) begin
      o_exccode = EXC_OV;
    end else if (i_flags.sys) begin
      o_exccode = EXC_SYS;
    end else if (i_flags.bp) begin
      o_exccode = EXC_BP;
    end else if (i_flags.adel) begin
      o_exccode = EXC_ADEL;
      o_bv_sel  = BV_DATA;
    end else if (i_flags.ades) begin
      o_exccode = EXC_ADES;
      o_bv_sel  = BV_DATA;
    end else begin
      o_hit = 1'b0;
    end
  end

endmodule

// File: rtl/exc_commit_ctrl.sv
// WB-stage exception/interrupt/ERET commit controller with flush and fetch redirect
// handshake. Optional EXC_HWINT_EN adds synchronised hardware interrupt lines.
module exc_commit_ctrl
  import exc_pkg::*;
#(
  parameter int               PC_W       = 32,
  parameter logic [PC_W-1:0]  EXC_VECTOR = PC_W'(EXC_VECTOR_DEFAULT)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_ready,
  input  logic             i_complete,
  input  logic             i_mem_valid,
  input  logic [PC_W-1:0]  i_mem_pc,
  input  logic             i_mem_bd,
  input  logic             i_mem_exc_fadel,
  input  logic             i_mem_exc_ri,
  input  logic             i_mem_exc_ov,
  input  logic             i_mem_exc_sys,
  input  logic             i_mem_exc_bp,
  input  logic             i_mem_exc_adel,
  input  logic             i_mem_exc_ades,
  input  logic [PC_W-1:0]  i_mem_data_addr,
  input  logic             i_mem_eret,
  input  logic             i_cp0_status_ie,
  input  logic             i_cp0_status_exl,
  input  logic             i_cp0_status_im0,
  input  logic             i_cp0_status_im1,
  input  logic             i_cp0_cause_ip0,
  input  logic             i_cp0_cause_ip1,
  input  logic [PC_W-1:0]  i_cp0_epc_val,
  input  logic [31:0]      i_cp0_status_val,
  input  logic [5:0]       i_hw_int,
  input  logic             i_redirect_ack,
  output logic             o_exception_inst_interrupt,
  output logic             o_wb_exception_inst_exchappen,
  output logic             o_wb_exception_inst_bd,
  output logic             o_wb_exception_inst_badvaddr_wren,
  output logic [PC_W-1:0]  o_wb_exception_inst_epc,
  output logic [PC_W-1:0]  o_wb_exception_inst_badvaddr,
  output logic [4:0]       o_wb_exception_inst_exccode,
  output logic             o_inst_eret,
  output logic             o_flush,
  output logic             o_redirect_valid,
  output logic [PC_W-1:0]  o_redirect_pc
);

  commit_state_e    r_state;
  commit_state_e    w_state_next;
  logic             r_wb_valid;
  logic [PC_W-1:0]  r_wb_pc;
  logic             r_wb_bd;
  exc_flags_t       r_wb_flags;
  logic [PC_W-1:0]  r_wb_data_addr;
  logic             r_wb_eret;
  logic [PC_W-1:0]  r_redirect_pc;

  exc_flags_t       w_mem_flags;
  logic             w_advance;
  logic             w_hw_term;
  logic             w_int_pend;
  logic             w_interrupt;
  logic             w_exchappen;
  logic             w_inst_eret;
  logic             w_hit;
  logic [4:0]       w_exccode;
  bv_sel_e          w_bv_sel;
  logic             w_flush;
  logic             w_redirect_valid;
  logic             w_latch;

  assign w_advance   = i_ready & i_complete;
  assign w_mem_flags = {i_mem_exc_fadel, i_mem_exc_ri, i_mem_exc_ov, i_mem_exc_sys,
                        i_mem_exc_bp, i_mem_exc_adel, i_mem_exc_ades};

`ifdef EXC_HWINT_EN
  logic [5:0] r_hw_sync1;
  logic [5:0] r_hw_sync2;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_hw_sync1 <= '0;
      r_hw_sync2 <= '0;
    end else begin
      r_hw_sync1 <= i_hw_int;
      r_hw_sync2 <= r_hw_sync1;
    end
  end

  assign w_hw_term = |(r_hw_sync2 & i_cp0_status_val[15:10]);
  wire w_unused_status = ^{i_cp0_status_val[31:16], i_cp0_status_val[9:0]};
`else
  assign w_hw_term = 1'b0;
  wire w_unused_hw = ^{i_hw_int, i_cp0_status_val};
`endif

  exc_prio_enc u_prio_enc (
    .i_flags   (r_wb_flags),
    .o_hit     (w_hit),
    .o_exccode (w_exccode),
    .o_bv_sel  (w_bv_sel)
  );

  assign w_int_pend  = i_cp0_status_ie & ~i_cp0_status_exl &
                       ((i_cp0_cause_ip0 & i_cp0_status_im0) |
                        (i_cp0_cause_ip1 & i_cp0_status_im1) | w_hw_term);
  assign w_interrupt = r_wb_valid & w_int_pend & (r_state == ST_IDLE);
  assign w_exchappen = r_wb_valid & w_hit & ~w_interrupt;
  assign w_inst_eret = r_wb_valid & r_wb_eret & ~w_interrupt & ~w_exchappen;

  // WB capture: the flushing instruction's successor must never land in WB.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wb_valid     <= 1'b0;
      r_wb_pc        <= '0;
      r_wb_bd        <= 1'b0;
      r_wb_flags     <= '0;
      r_wb_data_addr <= '0;
      r_wb_eret      <= 1'b0;
    end else if (r_state == ST_REDIR) begin
      r_wb_valid <= 1'b0;
    end else if (w_advance) begin
      r_wb_valid     <= i_mem_valid & ~w_flush;
      r_wb_pc        <= i_mem_pc;
      r_wb_bd        <= i_mem_bd;
      r_wb_flags     <= w_mem_flags;
      r_wb_data_addr <= i_mem_data_addr;
      r_wb_eret      <= i_mem_eret;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_redirect_pc <= EXC_VECTOR;
    end else begin
      r_state <= w_state_next;
      if (w_latch) begin
        r_redirect_pc <= w_inst_eret ? i_cp0_epc_val : EXC_VECTOR;
      end
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_flush          = 1'b0;
    w_redirect_valid = 1'b0;
    w_latch          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_advance && (w_interrupt || w_exchappen || w_inst_eret)) begin
          w_flush      = 1'b1;
          w_latch      = 1'b1;
          w_state_next = ST_REDIR;
        end
      end
      ST_REDIR: begin
        w_redirect_valid = 1'b1;
        if (i_redirect_ack) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Data outputs are zeroed unless the matching event is being reported.
  assign o_exception_inst_interrupt        = w_interrupt;
  assign o_wb_exception_inst_exchappen     = w_exchappen;
  assign o_wb_exception_inst_exccode       = w_exchappen ? w_exccode : EXC_INT;
  assign o_wb_exception_inst_bd            = (w_exchappen | w_interrupt) & r_wb_bd;
  assign o_wb_exception_inst_epc           = (w_exchappen | w_interrupt) ?
                                             (r_wb_bd ? r_wb_pc - PC_W'(4) : r_wb_pc) : '0;
  assign o_wb_exception_inst_badvaddr_wren = w_exchappen & (w_bv_sel != BV_NONE);
  assign o_wb_exception_inst_badvaddr      = !w_exchappen        ? '0 :
                                             (w_bv_sel == BV_PC)   ? r_wb_pc :
                                             (w_bv_sel == BV_DATA) ? r_wb_data_addr : '0;
  assign o_inst_eret      = w_inst_eret;
  assign o_flush          = w_flush;
  assign o_redirect_valid = w_redirect_valid;
  assign o_redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Directed self-checking bench for exc_commit_ctrl; the hw-interrupt case runs
// only when EXC_HWINT_EN is defined.
module tb_exc_commit_ctrl;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_ready, i_complete, i_mem_valid, i_mem_bd;
  logic [31:0] i_mem_pc, i_mem_data_addr;
  logic        i_mem_exc_fadel, i_mem_exc_ri, i_mem_exc_ov, i_mem_exc_sys;
  logic        i_mem_exc_bp, i_mem_exc_adel, i_mem_exc_ades, i_mem_eret;
  logic        i_cp0_status_ie, i_cp0_status_exl, i_cp0_status_im0, i_cp0_status_im1;
  logic        i_cp0_cause_ip0, i_cp0_cause_ip1;
  logic [31:0] i_cp0_epc_val, i_cp0_status_val;
  logic [5:0]  i_hw_int;
  logic        i_redirect_ack;
  logic        o_exception_inst_interrupt, o_wb_exception_inst_exchappen;
  logic        o_wb_exception_inst_bd, o_wb_exception_inst_badvaddr_wren;
  logic [31:0] o_wb_exception_inst_epc, o_wb_exception_inst_badvaddr;
  logic [4:0]  o_wb_exception_inst_exccode;
  logic        o_inst_eret, o_flush, o_redirect_valid;
  logic [31:0] o_redirect_pc;

  int n_total = 0;
  int n_pass  = 0;

  localparam logic [31:0] VEC = 32'hBFC0_0380;

  always #5 i_clk = ~i_clk;

  exc_commit_ctrl dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_ready(i_ready), .i_complete(i_complete),
    .i_mem_valid(i_mem_valid), .i_mem_pc(i_mem_pc), .i_mem_bd(i_mem_bd),
    .i_mem_exc_fadel(i_mem_exc_fadel), .i_mem_exc_ri(i_mem_exc_ri),
    .i_mem_exc_ov(i_mem_exc_ov), .i_mem_exc_sys(i_mem_exc_sys),
    .i_mem_exc_bp(i_mem_exc_bp), .i_mem_exc_adel(i_mem_exc_adel),
    .i_mem_exc_ades(i_mem_exc_ades), .i_mem_data_addr(i_mem_data_addr),
    .i_mem_eret(i_mem_eret), .i_cp0_status_ie(i_cp0_status_ie),
    .i_cp0_status_exl(i_cp0_status_exl), .i_cp0_status_im0(i_cp0_status_im0),
    .i_cp0_status_im1(i_cp0_status_im1), .i_cp0_cause_ip0(i_cp0_cause_ip0),
    .i_cp0_cause_ip1(i_cp0_cause_ip1), .i_cp0_epc_val(i_cp0_epc_val),
    .i_cp0_status_val(i_cp0_status_val), .i_hw_int(i_hw_int),
    .i_redirect_ack(i_redirect_ack),
    .o_exception_inst_interrupt(o_exception_inst_interrupt),
    .o_wb_exception_inst_exchappen(o_wb_exception_inst_exchappen),
    .o_wb_exception_inst_bd(o_wb_exception_inst_bd),
    .o_wb_exception_inst_badvaddr_wren(o_wb_exception_inst_badvaddr_wren),
    .o_wb_exception_inst_epc(o_wb_exception_inst_epc),
    .o_wb_exception_inst_badvaddr(o_wb_exception_inst_badvaddr),
    .o_wb_exception_inst_exccode(o_wb_exception_inst_exccode),
    .o_inst_eret(o_inst_eret), .o_flush(o_flush),
    .o_redirect_valid(o_redirect_valid), .o_redirect_pc(o_redirect_pc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_mem();
    i_mem_valid = 1'b0; i_mem_pc = '0; i_mem_bd = 1'b0; i_mem_data_addr = '0;
    {i_mem_exc_fadel, i_mem_exc_ri, i_mem_exc_ov, i_mem_exc_sys,
     i_mem_exc_bp, i_mem_exc_adel, i_mem_exc_ades} = '0;
    i_mem_eret = 1'b0;
  endtask

  task automatic set_idle();
    clear_mem();
    i_ready = 1'b1; i_complete = 1'b1; i_redirect_ack = 1'b0;
    i_cp0_status_ie = 1'b0; i_cp0_status_exl = 1'b0;
    i_cp0_status_im0 = 1'b0; i_cp0_status_im1 = 1'b0;
    i_cp0_cause_ip0 = 1'b0; i_cp0_cause_ip1 = 1'b0;
    i_cp0_epc_val = '0; i_cp0_status_val = '0; i_hw_int = '0;
  endtask

  task automatic load_mem(input logic [6:0] f, input logic [31:0] pc, input logic bd,
                          input logic eret);
    i_mem_valid = 1'b1; i_mem_pc = pc; i_mem_bd = bd; i_mem_eret = eret;
    i_mem_data_addr = 32'hDEAD_0010;
    {i_mem_exc_fadel, i_mem_exc_ri, i_mem_exc_ov, i_mem_exc_sys,
     i_mem_exc_bp, i_mem_exc_adel, i_mem_exc_ades} = f;
  endtask

  task automatic finish_redirect(input logic [31:0] target);
    step();
    check("redir_hold_valid", 32'(o_redirect_valid), 32'd1);
    check("redir_hold_pc", o_redirect_pc, target);
    i_redirect_ack = 1'b1;
    step();
    i_redirect_ack = 1'b0;
    #1;
    check("redir_after_ack", 32'(o_redirect_valid), 32'd0);
  endtask

  // flags order: fadel ri ov sys bp adel ades
  task automatic run_exc(input string tag, input logic [6:0] f, input logic [31:0] pc,
                         input logic bd, input logic [4:0] code, input logic [31:0] epc,
                         input logic wren, input logic [31:0] bad);
    load_mem(f, pc, bd, 1'b0);
    step();
    clear_mem();
    #1;
    check({tag, "_exchappen"}, 32'(o_wb_exception_inst_exchappen), 32'd1);
    check({tag, "_exccode"}, 32'(o_wb_exception_inst_exccode), 32'(code));
    check({tag, "_epc"}, o_wb_exception_inst_epc, epc);
    check({tag, "_bd"}, 32'(o_wb_exception_inst_bd), 32'(bd));
    check({tag, "_bv_wren"}, 32'(o_wb_exception_inst_badvaddr_wren), 32'(wren));
    check({tag, "_badvaddr"}, o_wb_exception_inst_badvaddr, bad);
    check({tag, "_int"}, 32'(o_exception_inst_interrupt), 32'd0);
    check({tag, "_flush"}, 32'(o_flush), 32'd1);
    check({tag, "_rv_early"}, 32'(o_redirect_valid), 32'd0);
    step();
    check({tag, "_rv"}, 32'(o_redirect_valid), 32'd1);
    check({tag, "_rpc"}, o_redirect_pc, VEC);
    check({tag, "_flush_once"}, 32'(o_flush), 32'd0);
    check({tag, "_exc_gone"}, 32'(o_wb_exception_inst_exchappen), 32'd0);
    finish_redirect(VEC);
    $display("txn %s: code=%0d epc=%h", tag, code, epc);
  endtask

  initial begin
    i_reset = 1'b1;
    set_idle();
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_rv", 32'(o_redirect_valid), 32'd0);
    check("rst_rpc", o_redirect_pc, VEC);
    check("rst_flush", 32'(o_flush), 32'd0);
    check("rst_exc", 32'(o_wb_exception_inst_exchappen), 32'd0);
    i_reset = 1'b0;
    step();
    $display("txn reset released");

    // flags without mem_valid and ack in IDLE are both ignored
    load_mem(7'b0010000, 32'h8000_0800, 1'b0, 1'b0);
    i_mem_valid = 1'b0;
    i_redirect_ack = 1'b1;
    step();
    clear_mem();
    i_redirect_ack = 1'b0;
    #1;
    check("novalid_exc", 32'(o_wb_exception_inst_exchappen), 32'd0);
    check("novalid_flush", 32'(o_flush), 32'd0);
    check("idle_ack_rv", 32'(o_redirect_valid), 32'd0);
    $display("txn ignored flags/ack");

    run_exc("ov",     7'b0010000, 32'h8000_1000, 1'b0, 5'd12, 32'h8000_1000, 1'b0, 32'h0);
    run_exc("fadel",  7'b1000000, 32'h8000_0004, 1'b1, 5'd4,  32'h8000_0000, 1'b1, 32'h8000_0004);
    run_exc("ri_ov",  7'b0110000, 32'h8000_1100, 1'b0, 5'd10, 32'h8000_1100, 1'b0, 32'h0);
    run_exc("sys_bp", 7'b0001100, 32'h8000_1200, 1'b0, 5'd8,  32'h8000_1200, 1'b0, 32'h0);
    run_exc("bp",     7'b0000100, 32'h8000_1300, 1'b1, 5'd9,  32'h8000_12FC, 1'b0, 32'h0);
    run_exc("adel",   7'b0000011, 32'h8000_1400, 1'b0, 5'd4,  32'h8000_1400, 1'b1, 32'hDEAD_0010);
    run_exc("ades",   7'b0000001, 32'h8000_1500, 1'b0, 5'd5,  32'h8000_1500, 1'b1, 32'hDEAD_0010);

    // EXL masks the pending interrupt so RI is taken
    i_cp0_status_ie = 1'b1; i_cp0_status_exl = 1'b1;
    i_cp0_status_im0 = 1'b1; i_cp0_cause_ip0 = 1'b1;
    run_exc("ri_exl", 7'b0100000, 32'h8000_3100, 1'b0, 5'd10, 32'h8000_3100, 1'b0, 32'h0);

    // interrupt beats RI
    i_cp0_status_exl = 1'b0;
    load_mem(7'b0100000, 32'h8000_3000, 1'b0, 1'b0);
    step();
    clear_mem();
    #1;
    check("int_int", 32'(o_exception_inst_interrupt), 32'd1);
    check("int_exchappen", 32'(o_wb_exception_inst_exchappen), 32'd0);
    check("int_exccode", 32'(o_wb_exception_inst_exccode), 32'd0);
    check("int_epc", o_wb_exception_inst_epc, 32'h8000_3000);
    check("int_flush", 32'(o_flush), 32'd1);
    step();
    check("int_rpc", o_redirect_pc, VEC);
    check("int_redir_int", 32'(o_exception_inst_interrupt), 32'd0);
    finish_redirect(VEC);
    set_idle();
    $display("txn interrupt over RI");

    // ERET redirects to EPC
    i_cp0_epc_val = 32'h8000_2000;
    load_mem(7'b0, 32'h8000_0100, 1'b0, 1'b1);
    step();
    clear_mem();
    #1;
    check("eret_eret", 32'(o_inst_eret), 32'd1);
    check("eret_exc", 32'(o_wb_exception_inst_exchappen), 32'd0);
    check("eret_flush", 32'(o_flush), 32'd1);
    step();
    check("eret_rpc", o_redirect_pc, 32'h8000_2000);
    finish_redirect(32'h8000_2000);
    $display("txn eret");

    // stalled trigger fires only once complete returns
    load_mem(7'b0010000, 32'h8000_4000, 1'b0, 1'b0);
    step();
    clear_mem();
    i_complete = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_flush", 32'(o_flush), 32'd0);
      check("stall_exc_held", 32'(o_wb_exception_inst_exchappen), 32'd1);
      step();
      check("stall_rv", 32'(o_redirect_valid), 32'd0);
    end
    i_complete = 1'b1;
    #1;
    check("stall_fire_flush", 32'(o_flush), 32'd1);
    step();
    check("stall_fire_rv", 32'(o_redirect_valid), 32'd1);
    finish_redirect(VEC);
    $display("txn stalled trigger");

    // reset while redirecting
    i_cp0_epc_val = 32'h8000_5000;
    load_mem(7'b0, 32'h8000_0200, 1'b0, 1'b1);
    step();
    clear_mem();
    step();
    check("rr_rpc_pre", o_redirect_pc, 32'h8000_5000);
    i_reset = 1'b1;
    #1;
    check("rr_rv", 32'(o_redirect_valid), 32'd0);
    check("rr_rpc", o_redirect_pc, VEC);
    step();
    i_reset = 1'b0;
    step();
    check("rr_idle_rv", 32'(o_redirect_valid), 32'd0);
    set_idle();
    $display("txn reset in redirect");

`ifdef EXC_HWINT_EN
    i_cp0_status_ie = 1'b1;
    i_cp0_status_val = 32'h0000_0400;
    load_mem(7'b0, 32'h8000_6000, 1'b0, 1'b0);
    step();
    clear_mem();
    i_complete = 1'b0;
    i_hw_int = 6'b000001;
    #1;
    check("hw_int_c0", 32'(o_exception_inst_interrupt), 32'd0);
    step();
    check("hw_int_c1", 32'(o_exception_inst_interrupt), 32'd0);
    step();
    check("hw_int_c2", 32'(o_exception_inst_interrupt), 32'd1);
    i_complete = 1'b1;
    #1;
    check("hw_int_flush", 32'(o_flush), 32'd1);
    step();
    i_hw_int = '0;
    finish_redirect(VEC);
    set_idle();
    $display("txn hw interrupt");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
